// File: rtl/p2_eval_sequencer.sv
// p2_eval_sequencer: grades a small asynchronous 2-in/1-out logic cell.
// It drives each input vector in turn and waits a settling window. It then
// samples the synchronized cell output over a fixed window and grades the
// majority value against EXPECTED. It reports score, stability mask and the
// observed truth table.
//
// Optional feature: define P2_TESTER_TOGGLE_EN to count output transitions
// seen during sample windows (saturating 16-bit). Otherwise toggles is 0.
//
// Ports:
//   clk       in   clock for all logic
//   reset     in   synchronous, active-high
//   start     in   run a full evaluation (accepted only when idle)
//   dut_in    out  [1:0] input vector applied to the cell
//   dut_out   in   cell output, asynchronous to clk
//   busy      out  high from start acceptance through the last EVAL
//   done      out  one-cycle pulse when results are valid
//   result    out  [3:0] majority sampled value per vector
//   unstable  out  [3:0] output changed inside the vector's sample window
//   score     out  [2:0] number of vectors graded correct (0..4)
//   toggles   out  [15:0] transition count (0 unless feature enabled)
module p2_eval_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLE_CYCLES = 32,
  parameter logic [3:0]  EXPECTED      = 4'b0110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [1:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [3:0]  result,
  output logic [3:0]  unstable,
  output logic [2:0]  score,
  output logic [15:0] toggles
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ONES_W  = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic              fail_q, fail_d;
  logic              prev_q, prev_d;
  logic [1:0]        sync_q;
  logic [1:0]        dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        result_q, result_d;
  logic [3:0]        unstable_q, unstable_d;
  logic [2:0]        score_q, score_d;

  logic s;
  logic changed;
  logic majority;

  assign s = sync_q[1];
  // First sample of a window (cnt_q == 0) has no predecessor to compare.
  assign changed  = (cnt_q != '0) && (s != prev_q);
  // Strict majority; an exact tie grades as 0.
  assign majority = {ones_q, 1'b0} > (ONES_W + 1)'(SAMPLE_CYCLES);

  // State register, synchronizer and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ones_q     <= '0;
      fail_q     <= 1'b0;
      prev_q     <= 1'b0;
      sync_q     <= 2'b00;
      dut_in_q   <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 4'b0000;
      unstable_q <= 4'b0000;
      score_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      fail_q     <= fail_d;
      prev_q     <= prev_d;
      sync_q     <= {sync_q[0], dut_out};
      dut_in_q   <= dut_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      unstable_q <= unstable_d;
      score_q    <= score_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    fail_d     = fail_q;
    prev_d     = prev_q;
    dut_in_d   = dut_in_q;
    result_d   = result_q;
    unstable_d = unstable_q;
    score_d    = score_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETTLE;
          cnt_d      = '0;
          ones_d     = '0;
          fail_d     = 1'b0;
          dut_in_d   = 2'd0;
          result_d   = 4'b0000;
          unstable_d = 4'b0000;
          score_d    = 3'd0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        ones_d = ones_q + ONES_W'(s);
        prev_d = s;
        if (changed) fail_d = 1'b1;
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d = S_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EVAL: begin
        result_d[dut_in_q]   = majority;
        unstable_d[dut_in_q] = fail_q;
        if (!fail_q && (majority == EXPECTED[dut_in_q])) score_d = score_q + 3'd1;
        ones_d = '0;
        fail_d = 1'b0;
        cnt_d  = '0;
        if (dut_in_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_SETTLE;
          dut_in_d = dut_in_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE) || (state_d == S_EVAL);
    done_d = (state_d == S_DONE);
  end

`ifdef P2_TESTER_TOGGLE_EN
  logic [15:0] toggles_q, toggles_d;
  logic        tgl_clr_c;
  logic        tgl_inc_c;

  assign tgl_clr_c = (state_q == S_IDLE) && start;
  assign tgl_inc_c = (state_q == S_SAMPLE) && changed;

  // Saturating transition counter, summed over all vectors of a run.
  always_comb begin
    toggles_d = toggles_q;
    if (tgl_clr_c) begin
      toggles_d = 16'h0000;
    end else if (tgl_inc_c && (toggles_q != 16'hFFFF)) begin
      toggles_d = toggles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) toggles_q <= 16'h0000;
    else       toggles_q <= toggles_d;
  end

  assign toggles = toggles_q;
`else
  assign toggles = 16'h0000;
`endif

  assign dut_in   = dut_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign unstable = unstable_q;
  assign score    = score_q;

endmodule

// File: tb/tb_p2_eval_sequencer.sv
// Directed bench for p2_eval_sequencer with a behavioural cell model.
module tb_p2_eval_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  dut_in;
  logic        dut_out;
  logic        busy;
  logic        done;
  logic [3:0]  result;
  logic [3:0]  unstable;
  logic [2:0]  score;
  logic [15:0] toggles;

  int   errors;
  int   checks;
  int   mode;
  logic tg;

`ifdef P2_TESTER_TOGGLE_EN
  localparam logic [15:0] TGL_EXP = 16'd31;
`else
  localparam logic [15:0] TGL_EXP = 16'd0;
`endif

  p2_eval_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .unstable (unstable),
    .score    (score),
    .toggles  (toggles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial tg = 1'b0;
  always @(negedge clk) tg <= ~tg;

  // Cell model: 0 = XOR, 1 = tied high, 2 = XOR but oscillating for vector 2.
  always_comb begin
    case (mode)
      1:       dut_out = 1'b1;
      2:       dut_out = (dut_in == 2'd2) ? tg : (dut_in[0] ^ dut_in[1]);
      default: dut_out = dut_in[0] ^ dut_in[1];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int m, input logic [3:0] er, input logic [3:0] eu,
                     input logic [2:0] es, input logic [15:0] et, input bit repulse);
    int n;
    int done_at;
    int both;
    int extra;
    mode = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_on_start", 32'(busy), 32'd1);
    chk("dut_in_on_start", 32'(dut_in), 32'd0);
    chk("score_cleared", 32'(score), 32'd0);
    chk("result_cleared", 32'(result), 32'd0);
    n = 1;
    done_at = 0;
    both = 0;
    while (done_at == 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (repulse) start = (n == 60);
      if (busy && done) both++;
      if (done) done_at = n;
    end
    chk("done_latency", 32'(done_at), 32'd197);
    chk("busy_done_overlap", 32'(both), 32'd0);
    chk("result", 32'(result), 32'(er));
    chk("unstable", 32'(unstable), 32'(eu));
    chk("score", 32'(score), 32'(es));
    chk("toggles", 32'(toggles), 32'(et));
    chk("dut_in_final", 32'(dut_in), 32'd3);
    if (repulse) begin
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("start_in_done_ignored", 32'(busy), 32'd0);
      chk("single_done_pulse", 32'(done), 32'd0);
      chk("dut_in_hold_idle", 32'(dut_in), 32'd3);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("start_after_done_busy", 32'(busy), 32'd1);
      chk("start_after_done_dut_in", 32'(dut_in), 32'd0);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
    end else begin
      extra = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("no_extra_done", 32'(extra), 32'd0);
      chk("score_hold", 32'(score), 32'(es));
      chk("result_hold", 32'(result), 32'(er));
    end
  endtask

  initial begin
    int n;
    int dn;
    errors = 0;
    checks = 0;
    mode   = 0;
    reset  = 1'b1;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_unstable", 32'(unstable), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_toggles", 32'(toggles), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    run(0, 4'b0110, 4'b0000, 3'd4, 16'd0, 1'b0);
    run(1, 4'b1111, 4'b0000, 3'd2, 16'd0, 1'b0);
    run(2, 4'b0010, 4'b0100, 3'd3, TGL_EXP, 1'b0);
    run(0, 4'b0110, 4'b0000, 3'd4, 16'd0, 1'b1);

    // Reset mid-run, then confirm no done for the aborted run.
    mode = 0;
    repeat (3) @(negedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrun_score", 32'(score), 32'd2);
    chk("midrun_dut_in", 32'(dut_in), 32'd2);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_dut_in", 32'(dut_in), 32'd0);
    chk("abort_score", 32'(score), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_unstable", 32'(unstable), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    dn = 0;
    repeat (250) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    run(0, 4'b0110, 4'b0000, 3'd4, 16'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
